mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit, directly downstream of the EX/MEM pipeline register.
- Consumes the registered address, store data and memory control fields, runs a req/ack transaction on the data-memory bus, and returns aligned, extended load data toward MEM/WB.
- Drives the stall that freezes EX/MEM and the upstream stages while a bus access is outstanding.

---
 rtl/mem_stage_lsu.sv | 150 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: runs one req/ack data-bus transaction per
// EX/MEM instruction and returns lane-aligned, extended load data to MEM/WB.
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXMEMALUResult,
  input  logic [31:0] EXMEMMemWriteData,
  input  logic        EXMEMMemWrite,
  input  logic [2:0]  EXMEMMemWrBits,
  input  logic        EXMEMMemRead,
  input  logic [1:0]  EXMEMMemRBits,
  input  logic        load_unsigned,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  count;
  logic [1:0]  ld_lane;
  logic        ld_word, ld_half, ld_uns;

  logic        wr_ok, rd_ok, is_store, is_load, sz_word, sz_half, go;
  logic [1:0]  lane;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, shifted, load_val;

  assign lane     = EXMEMALUResult[1:0];
  assign wr_ok    = EXMEMMemWrite & ((EXMEMMemWrBits == 3'b001) |
                                     (EXMEMMemWrBits == 3'b010) |
                                     (EXMEMMemWrBits == 3'b100));
  assign rd_ok    = EXMEMMemRead & (EXMEMMemRBits != 2'b11);
  assign is_store = wr_ok;
  assign is_load  = ~wr_ok & rd_ok;

  // Size decode and lane placement; a write that is also a read is treated as the write.
  always_comb begin
    sz_word = 1'b0;
    sz_half = 1'b0;
    if (is_store) begin
      sz_word = EXMEMMemWrBits[2];
      sz_half = EXMEMMemWrBits[1];
    end else if (is_load) begin
      sz_word = (EXMEMMemRBits == 2'b00);
      sz_half = (EXMEMMemRBits == 2'b01);
    end
    if (sz_word) begin
      be_n    = 4'b1111;
      wdata_n = EXMEMMemWriteData;
    end else if (sz_half) begin
      be_n    = 4'b0011 << lane;
      wdata_n = {2{EXMEMMemWriteData[15:0]}};
    end else begin
      be_n    = 4'b0001 << lane;
      wdata_n = {4{EXMEMMemWriteData[7:0]}};
    end
  end

  assign mem_misalign = (is_store | is_load) &
                        ((sz_word & (lane != 2'b00)) | (sz_half & lane[0]));
  assign go           = (is_store | is_load) & ~mem_misalign;

  // Combinational so the pipeline registers see it settled before their negedge capture.
  assign mem_stall = ((state == IDLE) & go) | (state == REQ);

  assign shifted = bus_rdata >> {ld_lane, 3'b000};

  always_comb begin
    if (ld_word)
      load_val = bus_rdata;
    else if (ld_half)
      load_val = {{16{~ld_uns & shifted[15]}}, shifted[15:0]};
    else
      load_val = {{24{~ld_uns & shifted[7]}}, shifted[7:0]};
  end

  // Transaction FSM; an ack in the same cycle as the timeout takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      ld_lane   <= '0;
      ld_word   <= 1'b0;
      ld_half   <= 1'b0;
      ld_uns    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            bus_addr  <= {EXMEMALUResult[31:2], 2'b00};
            bus_we    <= is_store;
            bus_be    <= be_n;
            bus_wdata <= wdata_n;
            ld_lane   <= lane;
            ld_word   <= sz_word;
            ld_half   <= sz_half;
            ld_uns    <= load_unsigned;
            bus_req   <= 1'b1;
            count     <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!bus_we)
              mem_rdata <= load_val;
            bus_req <= 1'b0;
            count   <= '0;
            state   <= RESP;
          end else if (count == LAST) begin
            bus_req   <= 1'b0;
            bus_err   <= 1'b1;
            mem_rdata <= '0;
            count     <= '0;
            state     <= RESP;
          end else begin
            count <= count + 8'd1;
          end
        end
        RESP: begin
          bus_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised bench for mem_stage_lsu against a byte-lane reference model.
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EXMEMALUResult, EXMEMMemWriteData;
  logic        EXMEMMemWrite, EXMEMMemRead, load_unsigned;
  logic [2:0]  EXMEMMemWrBits;
  logic [1:0]  EXMEMMemRBits;
  logic        mem_stall, mem_misalign, bus_err, bus_req, bus_we, bus_ack;
  logic [31:0] mem_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;
  logic [31:0] modelRdata = '0;

  mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .EXMEMALUResult(EXMEMALUResult), .EXMEMMemWriteData(EXMEMMemWriteData),
    .EXMEMMemWrite(EXMEMMemWrite), .EXMEMMemWrBits(EXMEMMemWrBits),
    .EXMEMMemRead(EXMEMMemRead), .EXMEMMemRBits(EXMEMMemRBits),
    .load_unsigned(load_unsigned),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_misalign(mem_misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    EXMEMALUResult = '0; EXMEMMemWriteData = '0;
    EXMEMMemWrite = 1'b0; EXMEMMemWrBits = 3'b000;
    EXMEMMemRead = 1'b0; EXMEMMemRBits = 2'b11;
    load_unsigned = 1'b0;
  endtask

  // One instruction through the stage; ackDelay counts REQ cycles before the ack (>= TIMEOUT means none).
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wd,
                               input logic wr, input logic [2:0] wrBits,
                               input logic rd, input logic [1:0] rBits, input logic uns,
                               input int ackDelay, input logic [31:0] rdata);
    bit wrOk, rdOk, mis, go, timeout;
    int size, lane, reqSeen, stallSeen, expReq;
    logic [31:0] mask, expBe, expWdata, val;
    wrOk = wr && (wrBits == 3'd1 || wrBits == 3'd2 || wrBits == 3'd4);
    rdOk = rd && (rBits != 2'd3);
    size = wrOk ? (wrBits == 3'd4 ? 4 : wrBits == 3'd2 ? 2 : 1)
         : rdOk ? (rBits == 2'd0 ? 4 : rBits == 2'd1 ? 2 : 1) : 0;
    lane = int'(addr % 4);
    mis  = (size != 0) && (addr % size != 0);
    go   = (size != 0) && !mis;
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 1;
    expBe    = ((32'd1 << size) - 1) << lane;
    expWdata = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101
             : (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;

    @(posedge clk); #1;
    EXMEMALUResult = addr; EXMEMMemWriteData = wd; EXMEMMemWrite = wr;
    EXMEMMemWrBits = wrBits; EXMEMMemRead = rd; EXMEMMemRBits = rBits; load_unsigned = uns;
    @(negedge clk);
    checkOutput("misalign", 32'(mem_misalign), 32'(mis));
    checkOutput("idle_stall", 32'(mem_stall), 32'(go));
    if (!go) begin
      checkOutput("nogo_req", 32'(bus_req), 32'd0);
      checkOutput("nogo_rdata", mem_rdata, modelRdata);
      clearInputs();
      return;
    end

    @(posedge clk); #1;
    checkOutput("bus_addr", bus_addr, addr - 32'(lane));
    checkOutput("bus_we", 32'(bus_we), 32'(wrOk));
    checkOutput("bus_be", 32'(bus_be), expBe);
    if (wrOk) checkOutput("bus_wdata", bus_wdata, expWdata);

    reqSeen = 0; stallSeen = 1;
    for (int guard = 0; guard < 100; guard++) begin
      @(negedge clk);
      if (!mem_stall) break;
      stallSeen++;
      if (bus_req) reqSeen++;
      if (reqSeen - 1 == ackDelay) begin bus_ack = 1'b1; bus_rdata = rdata; end
      else begin bus_ack = 1'b0; bus_rdata = $urandom; end
    end
    bus_ack = 1'b0;

    timeout = (ackDelay >= TIMEOUT);
    expReq  = timeout ? TIMEOUT : ackDelay + 1;
    if (timeout) modelRdata = '0;
    else if (!wrOk) begin
      val = (rdata >> (8 * lane)) & mask;
      if (!uns && size < 4 && val[8 * size - 1]) val = val | ~mask;
      modelRdata = val;
    end
    checkOutput("req_cycles", 32'(reqSeen), 32'(expReq));
    checkOutput("stall_cycles", 32'(stallSeen), 32'(expReq + 1));
    checkOutput("resp_err", 32'(bus_err), 32'(timeout));
    checkOutput("resp_req", 32'(bus_req), 32'd0);
    checkOutput("resp_rdata", mem_rdata, modelRdata);
    clearInputs();
    @(negedge clk);
    checkOutput("idle_err", 32'(bus_err), 32'd0);
    checkOutput("idle_stall_after", 32'(mem_stall), 32'd0);
  endtask

  initial begin
    logic [2:0] wrChoices [5];
    wrChoices = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd3};
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
    clearInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", 32'(bus_req), 32'd0);
    checkOutput("rst_we", 32'(bus_we), 32'd0);
    checkOutput("rst_addr", bus_addr, 32'd0);
    checkOutput("rst_be", 32'(bus_be), 32'd0);
    checkOutput("rst_wdata", bus_wdata, 32'd0);
    checkOutput("rst_rdata", mem_rdata, 32'd0);
    checkOutput("rst_err", 32'(bus_err), 32'd0);
    checkOutput("rst_stall", 32'(mem_stall), 32'd0);
    rst = 1'b0;

    applyStimulus(32'h100, 32'h0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b0, 2, 32'hDEADBEEF);
    applyStimulus(32'h103, 32'h0, 1'b0, 3'd0, 1'b1, 2'd2, 1'b0, 0, 32'h80112233);
    applyStimulus(32'h103, 32'h0, 1'b0, 3'd0, 1'b1, 2'd2, 1'b1, 1, 32'h80112233);
    applyStimulus(32'h202, 32'h0000ABCD, 1'b1, 3'd2, 1'b0, 2'd3, 1'b0, 0, 32'h0);
    applyStimulus(32'h101, 32'h0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b0, 0, 32'h0);
    applyStimulus(32'h40, 32'h0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b0, TIMEOUT - 1, 32'h13579BDF);
    applyStimulus(32'h44, 32'h0, 1'b0, 3'd0, 1'b1, 2'd1, 1'b0, 99, 32'h0);
    applyStimulus(32'h46, 32'h0000F00D, 1'b1, 3'd2, 1'b1, 2'd0, 1'b1, 3, 32'hFFFF_FFFF);

    // Ack with no access outstanding must leave everything untouched.
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk); bus_ack = 1'b0;
    checkOutput("stray_ack_req", 32'(bus_req), 32'd0);
    checkOutput("stray_ack_rdata", mem_rdata, modelRdata);

    for (int i = 0; i < 80; i++)
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), wrChoices[$urandom_range(0, 4)],
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 4), $urandom);

    // Asynchronous reset in the middle of a REQ phase.
    @(posedge clk); #1;
    EXMEMALUResult = 32'h300; EXMEMMemRead = 1'b1; EXMEMMemRBits = 2'd0;
    @(posedge clk); #1;
    checkOutput("pre_rst_req", 32'(bus_req), 32'd1);
    #3; rst = 1'b1; clearInputs();
    #1;
    modelRdata = '0;
    checkOutput("async_rst_req", 32'(bus_req), 32'd0);
    checkOutput("async_rst_stall", 32'(mem_stall), 32'd0);
    checkOutput("async_rst_rdata", mem_rdata, 32'd0);
    @(negedge clk); rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk); bus_ack = 1'b0;
    checkOutput("late_ack_req", 32'(bus_req), 32'd0);
    checkOutput("late_ack_rdata", mem_rdata, modelRdata);
    checkOutput("late_ack_stall", 32'(mem_stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
